// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute stage: ALU op codes,
// funct values, ALU control decode/eval, EX state and EX/MEM record layout.
package mips_pkg;

   localparam int REG_W  = 5;
   localparam int WORD_W = 32;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MULT = 6'h18;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_ZERO
   } alu_ctrl_e;

   typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_e;

   typedef struct packed {
      logic              valid;
      logic              branch;
      logic              jump;
      logic              memread;
      logic              memwrite;
      logic              regwrite;
      logic              memtoreg;
      logic [WORD_W-1:0] branch_target;
      logic [WORD_W-1:0] writedata;
      logic [REG_W-1:0]  write_reg;
   } ex_ctrl_t;

   typedef struct packed {
      ex_ctrl_t          ctrl;
      logic              zero;
      logic [WORD_W-1:0] result;
   } ex_mem_t;

   function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
      alu_ctrl_e ctrl;
      ctrl = ALU_ADD;
      case (aluop)
         ALUOP_SUB: ctrl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: ctrl = ALU_ADD;
               FUNCT_SUB: ctrl = ALU_SUB;
               FUNCT_AND: ctrl = ALU_AND;
               FUNCT_OR:  ctrl = ALU_OR;
               FUNCT_NOR: ctrl = ALU_NOR;
               FUNCT_SLT: ctrl = ALU_SLT;
               default:   ctrl = ALU_ZERO;
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
      return ctrl;
   endfunction

   function automatic logic [WORD_W-1:0] alu_eval(input alu_ctrl_e ctrl,
                                                  input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
      logic [WORD_W-1:0] r;
      r = '0;
      case (ctrl)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_NOR: r = ~(a | b);
         ALU_SLT: r = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_mem_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, MUL_CYCLES
// iterations, low WORD_W bits of the product kept. abort_i cancels a run.
module mul_iter
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   output logic              last_o,
   output logic [WORD_W-1:0] product_o
);

   localparam logic [4:0] CNT_LOAD = 5'(MUL_CYCLES - 1);

   logic              running_q;
   logic [4:0]        cnt_q;
   logic [WORD_W-1:0] mcand_q, mplier_q, acc_q, acc_d;

   assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign last_o    = running_q && (cnt_q == 5'd0);
   assign product_o = acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
      end else if (abort_i) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else if (start_i) begin
         running_q <= 1'b1;
         cnt_q     <= CNT_LOAD;
         mcand_q   <= a_i;
         mplier_q  <= b_i;
         acc_q     <= '0;
      end else if (running_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q == 5'd0) running_q <= 1'b0;
         else               cnt_q     <= cnt_q - 5'd1;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM register: ALU, branch target, dest select, iterative mult.
// Optional operand forwarding from EX/MEM and MEM/WB when FORWARD_EN is defined.
//
// state | meaning
// IDLE  | single-cycle ops flow straight into EX/MEM
// MUL   | multiplier iterating, upstream held
// DONE  | product ready, waiting for stall_in to drop
module ex_mem_stage
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              branch_in,
   input  logic              jump_in,
   input  logic              alusrc_in,
   input  logic              memread_in,
   input  logic              memwrite_in,
   input  logic              regwrite_in,
   input  logic              regdst_in,
   input  logic              memtoreg_in,
   input  logic [1:0]        aluop_in,
   input  logic [WORD_W-1:0] npc_in,
   input  logic [WORD_W-1:0] readdata1_in,
   input  logic [WORD_W-1:0] readdata2_in,
   input  logic [WORD_W-1:0] sigext_in,
   input  logic [REG_W-1:0]  rt_in,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              stall_in,
   input  logic              flush_in,
`ifdef FORWARD_EN
   input  logic [REG_W-1:0]  rs_in,
   input  logic              exmem_regwrite,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [WORD_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [WORD_W-1:0] memwb_data,
`endif
   output logic              ex_busy,
   output logic              valid_out,
   output logic              branch_out,
   output logic              jump_out,
   output logic              memread_out,
   output logic              memwrite_out,
   output logic              regwrite_out,
   output logic              memtoreg_out,
   output logic              zero_out,
   output logic [WORD_W-1:0] branch_target_out,
   output logic [WORD_W-1:0] alu_result_out,
   output logic [WORD_W-1:0] writedata_out,
   output logic [REG_W-1:0]  write_reg_out
);

   ex_state_e         state_q;
   ex_mem_t           exmem_q, ex_now, done_entry;
   ex_ctrl_t          pend_q;
   logic [WORD_W-1:0] rs_val, rt_val, op_a, op_b, alu_res, mul_product;
   logic              is_mult, mul_start, mul_last;

`ifdef FORWARD_EN
   function automatic logic [WORD_W-1:0] fwd(input logic [REG_W-1:0] src,
                                             input logic [WORD_W-1:0] regval);
      logic [WORD_W-1:0] v;
      v = regval;
      if (memwb_regwrite && memwb_rd != '0 && memwb_rd == src) v = memwb_data;
      if (exmem_regwrite && exmem_rd != '0 && exmem_rd == src) v = exmem_result;
      return v;
   endfunction

   always_comb begin
      rs_val = fwd(rs_in, readdata1_in);
      rt_val = fwd(rt_in, readdata2_in);
   end
`else
   always_comb begin
      rs_val = readdata1_in;
      rt_val = readdata2_in;
   end
`endif

   always_comb begin
      op_a    = rs_val;
      op_b    = alusrc_in ? sigext_in : rt_val;
      alu_res = alu_eval(alu_decode(aluop_in, sigext_in[5:0]), op_a, op_b);
      is_mult = (aluop_in == ALUOP_RTYPE) && (sigext_in[5:0] == FUNCT_MULT);

      ex_now                    = '0;
      ex_now.ctrl.valid         = 1'b1;
      ex_now.ctrl.branch        = branch_in;
      ex_now.ctrl.jump          = jump_in;
      ex_now.ctrl.memread       = memread_in;
      ex_now.ctrl.memwrite      = memwrite_in;
      ex_now.ctrl.regwrite      = regwrite_in;
      ex_now.ctrl.memtoreg      = memtoreg_in;
      ex_now.ctrl.branch_target = npc_in + {sigext_in[WORD_W-3:0], 2'b00};
      ex_now.ctrl.writedata     = rt_val;
      ex_now.ctrl.write_reg     = regdst_in ? rd_in : rt_in;
      ex_now.zero               = (alu_res == '0);
      ex_now.result             = alu_res;

      done_entry        = '0;
      done_entry.ctrl   = pend_q;
      done_entry.zero   = (mul_product == '0);
      done_entry.result = mul_product;
   end

   // Upstream only advances ID/EX on a cycle with ex_busy low, so a mult is
   // accepted only then; otherwise it would be presented again.
   assign mul_start = (state_q == IDLE) && in_valid && is_mult && !flush_in && !stall_in;
   assign ex_busy   = (state_q != IDLE) || stall_in;

   mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .abort_i   (flush_in),
      .a_i       (op_a),
      .b_i       (op_b),
      .last_o    (mul_last),
      .product_o (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         exmem_q <= '0;
         pend_q  <= '0;
      end else if (flush_in) begin
         state_q <= IDLE;
         exmem_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!stall_in) begin
                  if (mul_start) begin
                     state_q <= MUL;
                     pend_q  <= ex_now.ctrl;
                     exmem_q <= '0;
                  end else if (in_valid) begin
                     exmem_q <= ex_now;
                  end else begin
                     exmem_q <= '0;
                  end
               end
            end
            MUL: begin
               // Bubbles go downstream so the last result is not consumed twice.
               if (mul_last) state_q <= DONE;
               if (!stall_in) exmem_q <= '0;
            end
            DONE: begin
               if (!stall_in) begin
                  exmem_q <= done_entry;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign valid_out         = exmem_q.ctrl.valid;
   assign branch_out        = exmem_q.ctrl.branch;
   assign jump_out          = exmem_q.ctrl.jump;
   assign memread_out       = exmem_q.ctrl.memread;
   assign memwrite_out      = exmem_q.ctrl.memwrite;
   assign regwrite_out      = exmem_q.ctrl.regwrite;
   assign memtoreg_out      = exmem_q.ctrl.memtoreg;
   assign branch_target_out = exmem_q.ctrl.branch_target;
   assign writedata_out     = exmem_q.ctrl.writedata;
   assign write_reg_out     = exmem_q.ctrl.write_reg;
   assign zero_out          = exmem_q.zero;
   assign alu_result_out    = exmem_q.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage against a behavioural ALU/mult model.
module tb_ex_mem_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, branch_in, jump_in, alusrc_in, memread_in, memwrite_in;
   logic        regwrite_in, regdst_in, memtoreg_in, stall_in, flush_in;
   logic [1:0]  aluop_in;
   logic [31:0] npc_in, readdata1_in, readdata2_in, sigext_in;
   logic [4:0]  rt_in, rd_in;
   logic        ex_busy, valid_out, branch_out, jump_out, memread_out, memwrite_out;
   logic        regwrite_out, memtoreg_out, zero_out;
   logic [31:0] branch_target_out, alu_result_out, writedata_out;
   logic [4:0]  write_reg_out;
`ifdef FORWARD_EN
   logic [4:0]  rs_in, exmem_rd, memwb_rd;
   logic        exmem_regwrite, memwb_regwrite;
   logic [31:0] exmem_result, memwb_data;
`endif

   int checks = 0;
   int errors = 0;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .branch_in(branch_in), .jump_in(jump_in), .alusrc_in(alusrc_in),
      .memread_in(memread_in), .memwrite_in(memwrite_in), .regwrite_in(regwrite_in),
      .regdst_in(regdst_in), .memtoreg_in(memtoreg_in), .aluop_in(aluop_in),
      .npc_in(npc_in), .readdata1_in(readdata1_in), .readdata2_in(readdata2_in),
      .sigext_in(sigext_in), .rt_in(rt_in), .rd_in(rd_in),
      .stall_in(stall_in), .flush_in(flush_in),
`ifdef FORWARD_EN
      .rs_in(rs_in), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
      .memwb_rd(memwb_rd), .memwb_data(memwb_data),
`endif
      .ex_busy(ex_busy), .valid_out(valid_out), .branch_out(branch_out),
      .jump_out(jump_out), .memread_out(memread_out), .memwrite_out(memwrite_out),
      .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out), .zero_out(zero_out),
      .branch_target_out(branch_target_out), .alu_result_out(alu_result_out),
      .writedata_out(writedata_out), .write_reg_out(write_reg_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU straight from the operation table.
   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      if (op == 2'd1) return a - b;
      if (op != 2'd2) return a + b;
      case (f)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h27: return ~(a | b);
         6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return p[31:0];
   endfunction

   task automatic idle_inputs();
      in_valid = 0; branch_in = 0; jump_in = 0; alusrc_in = 0; memread_in = 0;
      memwrite_in = 0; regwrite_in = 0; regdst_in = 0; memtoreg_in = 0;
      aluop_in = 0; npc_in = 0; readdata1_in = 0; readdata2_in = 0; sigext_in = 0;
      rt_in = 0; rd_in = 0; stall_in = 0; flush_in = 0;
`ifdef FORWARD_EN
      rs_in = 0; exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
`endif
   endtask

   // Issue the currently driven instruction for one edge and compare EX/MEM with the model.
   task automatic issue_and_check(input string tag);
      logic [31:0] b, res, tgt;
      logic [4:0]  wr;
      logic        rw, mr;
      b   = alusrc_in ? sigext_in : readdata2_in;
      res = ref_alu(aluop_in, sigext_in[5:0], readdata1_in, b);
      tgt = npc_in + sigext_in * 4;
      wr  = regdst_in ? rd_in : rt_in;
      rw  = regwrite_in;
      mr  = memread_in;
      tick();
      chk({tag, ".valid"},  32'(valid_out), 32'd1);
      chk({tag, ".result"}, alu_result_out, res);
      chk({tag, ".zero"},   32'(zero_out), (res == 0) ? 32'd1 : 32'd0);
      chk({tag, ".wreg"},   32'(write_reg_out), 32'(wr));
      chk({tag, ".wdata"},  writedata_out, readdata2_in);
      chk({tag, ".target"}, branch_target_out, tgt);
      chk({tag, ".ctl"},    {30'd0, regwrite_out, memread_out}, {30'd0, rw, mr});
   endtask

   task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
      in_valid = 1; aluop_in = 2'b10; sigext_in = 32'h18; alusrc_in = 0;
      readdata1_in = a; readdata2_in = b; regdst_in = 1; rd_in = 5'd12; rt_in = 5'd2;
      regwrite_in = 1; npc_in = 32'h40;
      tick();
      in_valid = 0;
   endtask

   task automatic mult_check(input string tag, input logic [31:0] a, input logic [31:0] b);
      int n;
      start_mult(a, b);
      chk({tag, ".busy"}, 32'(ex_busy), 32'd1);
      n = 0;
      while (ex_busy && n < 100) begin
         tick();
         n++;
      end
      chk({tag, ".latency"}, n, 33);
      chk({tag, ".valid"},   32'(valid_out), 32'd1);
      chk({tag, ".result"},  alu_result_out, ref_mul(a, b));
      chk({tag, ".wreg"},    32'(write_reg_out), 32'd12);
      chk({tag, ".rw"},      32'(regwrite_out), 32'd1);
   endtask

   logic [5:0] functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h00};

   initial begin
      int n1;
      logic [31:0] ma, mb;
      idle_inputs();
      rst = 1;
      tick(); tick();
      chk("rst.valid",  32'(valid_out), 32'd0);
      chk("rst.result", alu_result_out, 32'd0);
      chk("rst.zero",   32'(zero_out), 32'd0);
      chk("rst.busy",   32'(ex_busy), 32'd0);
      rst = 0;

      // add 5+7 -> 12, rd=9
      in_valid = 1; aluop_in = 2'b10; sigext_in = 32'h20; readdata1_in = 5; readdata2_in = 7;
      regdst_in = 1; rd_in = 9; rt_in = 4; regwrite_in = 1;
      issue_and_check("add");
      chk("add.r12", alu_result_out, 32'd12);

      // beq compare
      aluop_in = 2'b01; regdst_in = 0; regwrite_in = 0; branch_in = 1; alusrc_in = 0;
      readdata1_in = 32'h1234; readdata2_in = 32'h1234; npc_in = 32'h100; sigext_in = 4;
      issue_and_check("beq");
      chk("beq.zero1", 32'(zero_out), 32'd1);
      chk("beq.tgt",   branch_target_out, 32'h110);
      chk("beq.br",    32'(branch_out), 32'd1);

      for (int i = 0; i < 30; i++) begin
         aluop_in    = 2'($urandom_range(0, 3));
         sigext_in   = {$urandom()} & 32'hFFFF_FFC0;
         sigext_in   = sigext_in | {26'd0, functs[$urandom_range(0, 7)]};
         alusrc_in   = 1'($urandom_range(0, 1));
         readdata1_in = $urandom();
         readdata2_in = ($urandom_range(0, 3) == 0) ? readdata1_in : $urandom();
         npc_in      = $urandom();
         rt_in = 5'($urandom()); rd_in = 5'($urandom());
         regdst_in = 1'($urandom()); regwrite_in = 1'($urandom()); memread_in = 1'($urandom());
         branch_in = 1'($urandom());
         issue_and_check($sformatf("rnd%0d", i));
      end

      idle_inputs();
      tick();
      chk("bubble.valid", 32'(valid_out), 32'd0);
      chk("bubble.rw",    32'(regwrite_out), 32'd0);

      // stall holds an or result
      in_valid = 1; aluop_in = 2'b10; sigext_in = 32'h25; readdata1_in = 32'hF0; readdata2_in = 32'h0F;
      regwrite_in = 1; rt_in = 7;
      issue_and_check("or");
      sigext_in = 32'h20; readdata1_in = 100; readdata2_in = 23; stall_in = 1;
      #1;
      chk("stall.busy", 32'(ex_busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall.hold%0d", i), alu_result_out, 32'hFF);
         chk($sformatf("stall.valid%0d", i), 32'(valid_out), 32'd1);
      end
      stall_in = 0;
      issue_and_check("after_stall");
      chk("after_stall.123", alu_result_out, 32'd123);

      idle_inputs();
      tick();
      mult_check("mul7x6", 32'd7, 32'd6);
      mult_check("mulFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         ma = $urandom(); mb = $urandom();
         mult_check($sformatf("mulrnd%0d", i), ma, mb);
      end

      // mult finishing under stall
      tick();
      ma = $urandom(); mb = $urandom();
      start_mult(ma, mb);
      for (int i = 0; i < 30; i++) tick();
      stall_in = 1;
      for (int i = 0; i < 8; i++) tick();
      chk("mulstall.valid", 32'(valid_out), 32'd0);
      chk("mulstall.busy",  32'(ex_busy), 32'd1);
      stall_in = 0;
      #1;
      chk("mulstall.done_busy", 32'(ex_busy), 32'd1);
      tick();
      chk("mulstall.valid1", 32'(valid_out), 32'd1);
      chk("mulstall.result", alu_result_out, ref_mul(ma, mb));
      chk("mulstall.idle",   32'(ex_busy), 32'd0);
      tick();
      chk("mulstall.once", 32'(valid_out), 32'd0);

      // flush mid-mult
      start_mult(32'd9, 32'd9);
      for (int i = 0; i < 10; i++) tick();
      flush_in = 1;
      tick();
      flush_in = 0;
      chk("flush.valid", 32'(valid_out), 32'd0);
      chk("flush.busy",  32'(ex_busy), 32'd0);
      n1 = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_out) n1++;
      end
      chk("flush.no_late", n1, 0);

      // reset mid-mult
      start_mult(32'd3, 32'd5);
      for (int i = 0; i < 10; i++) tick();
      rst = 1;
      tick();
      rst = 0;
      chk("rstmul.valid",  32'(valid_out), 32'd0);
      chk("rstmul.result", alu_result_out, 32'd0);
      chk("rstmul.wreg",   32'(write_reg_out), 32'd0);
      chk("rstmul.busy",   32'(ex_busy), 32'd0);
      n1 = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_out) n1++;
      end
      chk("rstmul.no_late", n1, 0);

      // flush beats stall
      in_valid = 1; aluop_in = 2'b00; readdata1_in = 1; readdata2_in = 2; regwrite_in = 1;
      issue_and_check("pre_flush");
      stall_in = 1; flush_in = 1;
      tick();
      chk("flushstall.valid", 32'(valid_out), 32'd0);
      chk("flushstall.rw",    32'(regwrite_out), 32'd0);
      idle_inputs();
      tick();

`ifdef FORWARD_EN
      in_valid = 1; aluop_in = 2'b00; alusrc_in = 0; rs_in = 3; rt_in = 4;
      readdata1_in = 999; readdata2_in = 1;
      exmem_regwrite = 1; exmem_rd = 3; exmem_result = 100;
      memwb_regwrite = 1; memwb_rd = 3; memwb_data = 50;
      tick();
      chk("fwd.exmem", alu_result_out, 32'd101);
      exmem_regwrite = 0;
      tick();
      chk("fwd.memwb", alu_result_out, 32'd51);
      exmem_regwrite = 1; rt_in = 3; readdata2_in = 0;
      tick();
      chk("fwd.wdata", writedata_out, 32'd100);
      rs_in = 0; rt_in = 4; readdata2_in = 1; exmem_rd = 0; memwb_rd = 0;
      tick();
      chk("fwd.r0", alu_result_out, 32'd1000);
      idle_inputs();
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage and EX/MEM pipeline register of the 5-stage MIPS core. Consumes the decoded controls and operands that the decode stage's ID/EX register drives. It performs:
- ALU operation
- branch-target and zero computation
- destination-register selection
- an iterative 32-cycle multiply

Results are registered into EX/MEM toward the memory stage. Stall and flush handshakes go upstream and downstream.

Parameters:
MUL_CYCLES, 32, iterations of the shift-add multiplier. Legal values are 1..32; the counter is 5 bits.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX holds a real instruction
branch_in, jump_in, alusrc_in, memread_in, memwrite_in, regwrite_in, regdst_in, memtoreg_in  in  1 each  ID/EX control bits
aluop_in  in  2  00 add, 01 sub, 10 R-type (funct), 11 reserved (treated as add)
npc_in  in  32  PC+4
readdata1_in, readdata2_in  in  32  register operands rs, rt
sigext_in  in  32  sign-extended immediate; funct = sigext_in[5:0]
rt_in, rd_in  in  5  instr[20:16], instr[15:11]
stall_in  in  1  memory stage cannot accept
flush_in  in  1  squash the instruction in EX
ex_busy  out  1  upstream must hold ID/EX
valid_out, branch_out, jump_out, memread_out, memwrite_out, regwrite_out, memtoreg_out  out  1 each  registered EX/MEM controls
zero_out  out  1  registered (alu_result == 0)
branch_target_out  out  32  npc_in + (sigext_in << 2)
alu_result_out  out  32  ALU or multiply result
writedata_out  out  32  store data (operand B before the immediate mux)
write_reg_out  out  5  regdst_in ? rd_in : rt_in

Behaviour:
- Reset, synchronous: all EX/MEM outputs are 0, FSM = IDLE, multiplier counter = 0.
- Operand A = readdata1_in. Operand B = alusrc_in ? sigext_in : readdata2_in.
- ALU, 32-bit, wrap on overflow, no traps:
  - add: A+B; sub: A-B.
  - funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 0 or 1).
  - Any other funct yields result 0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - If in_valid and not flush_in, and the op is not mult: EX/MEM loads at the next edge (1-cycle latency), unless stall_in.
  - If in_valid, aluop=10, funct 0x18: capture A and B, clear the accumulator, go to MUL. EX/MEM is not loaded.
- MUL: one shift-add per cycle. After MUL_CYCLES iterations go to DONE. Result = low 32 bits of the product.
- DONE: load EX/MEM with the product and stored controls when stall_in=0, then go to IDLE. While stall_in=1, stay in DONE.
- Mult latency: valid_out rises MUL_CYCLES+1 edges after the accepting edge, absent stall.
- ex_busy = (state != IDLE) || stall_in. This is combinational.
- stall_in=1: EX/MEM holds all values. The FSM still advances MUL to DONE.
- flush_in=1: at the next edge EX/MEM loads a bubble (valid and all control outputs 0; data fields don't-care, zero preferred). Any MUL or DONE aborts to IDLE.
- Flush has priority over stall and over completion in the same cycle.
- in_valid=0 in IDLE loads a bubble, unless stall_in.
- rst mid-multiply: return to IDLE, no output.

Optional Feature:
FORWARD_EN.
- Defined: adds the following ports:
  - rs_in (5)
  - exmem_regwrite (1), exmem_rd (5), exmem_result (32)
  - memwb_regwrite (1), memwb_rd (5), memwb_data (32)
- Forwarding rules:
  - Operand A (source rs) and readdata2 (source rt) each take exmem_result if exmem_regwrite, exmem_rd != 0 and it matches the source register.
  - Otherwise they take memwb_data on a matching memwb write.
  - EX/MEM has priority over MEM/WB.
  - The forwarded readdata2 also feeds writedata_out.
  - Multiply captures the forwarded values at acceptance.
- Undefined: operands come directly from the inputs; none of these ports exist.

Decomposition:
- Package mips_pkg:
  - aluop codes
  - funct constants (ADD, SUB, AND, OR, NOR, SLT, MULT)
  - alu_ctrl enum
  - ex_state enum {IDLE, MUL, DONE}
  - REG_W = 5
  - WORD_W = 32
- Sub-module mul_iter: the shift-add multiplier with start, done and abort.
- ALU decode stays inline.

Test Plan:
- add: aluop=10, funct 0x20, A=5, B=7, regdst=1, rd=9 -> next edge valid_out=1, alu_result_out=12, write_reg_out=9, zero_out=0.
- beq compare: aluop=01, A=B=0x1234, npc=0x100, sigext=4 -> alu_result_out=0, zero_out=1, branch_target_out=0x110.
- mult: funct 0x18, A=7, B=6 -> ex_busy high for 33 cycles, then valid_out=1 and alu_result_out=42. With A=B=0xFFFFFFFF -> alu_result_out=1.
- stall_in held 3 cycles after an or (0xF0|0x0F) -> EX/MEM holds 0xFF. Mult finishing under stall stays in DONE and loads once stall drops.
- flush_in 10 cycles into a mult -> next edge valid_out=0, ex_busy=0. Rst mid-mult behaves the same, with all outputs 0.
- FORWARD_EN, add with rs=3: exmem_rd=3, exmem_result=100 and memwb_rd=3, memwb_data=50, B=1 -> result 101. rd=0 match -> no forwarding.
